// File: rtl/mem_bridge_if.sv
// mem_bridge_if: CPU-side request/ack signals and RAM-side port of mem_bridge.
//   slave  : bridge view (takes fetch/data requests, drives the RAM port)
//   master : harness view (CPU core plus RAM model)
// Signals:
//   i_req/i_addr -> i_rdata/i_ack                     instruction fetch
//   d_req/d_we/d_size/d_signed/d_addr/d_wdata
//                -> d_rdata/d_ack                     data load/store
//   busy, fault                                       status
//   m_en/m_we/m_be/m_addr/m_wdata -> m_rdata          single-port RAM
interface mem_bridge_if #(
   parameter int unsigned DEPTH_LOG2 = 11
);
   logic                  i_req;
   logic [31:0]           i_addr;
   logic [31:0]           i_rdata;
   logic                  i_ack;
   logic                  d_req;
   logic                  d_we;
   logic [1:0]            d_size;
   logic                  d_signed;
   logic [31:0]           d_addr;
   logic [31:0]           d_wdata;
   logic [31:0]           d_rdata;
   logic                  d_ack;
   logic                  busy;
   logic                  fault;
   logic                  m_en;
   logic                  m_we;
   logic [3:0]            m_be;
   logic [DEPTH_LOG2-1:0] m_addr;
   logic [31:0]           m_wdata;
   logic [31:0]           m_rdata;

   modport slave (
      input  i_req, i_addr, d_req, d_we, d_size, d_signed, d_addr, d_wdata, m_rdata,
      output i_rdata, i_ack, d_rdata, d_ack, busy, fault,
             m_en, m_we, m_be, m_addr, m_wdata
   );

   modport master (
      output i_req, i_addr, d_req, d_we, d_size, d_signed, d_addr, d_wdata, m_rdata,
      input  i_rdata, i_ack, d_rdata, d_ack, busy, fault,
             m_en, m_we, m_be, m_addr, m_wdata
   );
endinterface

// File: rtl/mem_bridge.sv
// mem_bridge: multi-cycle bridge between the CPU fetch/data ports and one
// single-port synchronous word RAM. Translates text/data byte addresses into
// word indices, steers byte/half lanes for stores and sign/zero-extends loads.
// Data requests win over fetches when both are pending.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - mem_bridge_if.slave (CPU request/ack side and RAM side)
//
// Optional feature: define MEM_FAULT_EN to flag misaligned or out-of-range
// accesses (no RAM access, rdata 0, fault pulsed with the ack). Without it,
// fault stays 0, low address bits are ignored and offsets wrap in the RAM.
//
// state | meaning
// IDLE  | waiting for a request; data request has priority
// IACC  | fetch RAM window (WAIT_STATES+1 cycles), or one cycle when faulting
// DACC  | data RAM window (WAIT_STATES+1 cycles), or one cycle when faulting
// ACK   | result ready; ack and rdata are registered on leaving this state
module mem_bridge #(
   parameter int unsigned DEPTH_LOG2  = 11,
   parameter int unsigned WAIT_STATES = 1,
   parameter logic [31:0] IBASE       = 32'h0040_0000,
   parameter logic [31:0] DBASE       = 32'h1001_0000
) (
   input logic         clk,
   input logic         rst,
   mem_bridge_if.slave bus
);
   localparam int unsigned OW = DEPTH_LOG2 + 2;

   typedef enum logic [1:0] {IDLE, IACC, DACC, ACK} state_t;

   state_t                state_q, state_d;
   logic [2:0]            wait_q, wait_d;
   logic                  is_d_q, is_d_d;
   logic                  st_q, st_d;
   logic [1:0]            size_q, size_d;
   logic                  sgn_q, sgn_d;
   logic [1:0]            lane_q, lane_d;
   logic                  flt_q, flt_d;
   logic [31:0]           rd_q, rd_d;
   logic                  m_en_q, m_en_d;
   logic                  m_we_q, m_we_d;
   logic [3:0]            m_be_q, m_be_d;
   logic [DEPTH_LOG2-1:0] m_addr_q, m_addr_d;
   logic [31:0]           m_wdata_q, m_wdata_d;
   logic                  i_ack_q, i_ack_d;
   logic                  d_ack_q, d_ack_d;
   logic [31:0]           i_rdata_q, i_rdata_d;
   logic [31:0]           d_rdata_q, d_rdata_d;
   logic                  fault_q, fault_d;

   logic [1:0]            req_size;
   logic [OW-1:0]         off;
   logic                  acc_fault;
   logic                  is_store;
   logic [3:0]            st_be;
   logic [31:0]           st_wdata;
   logic [7:0]            byte_v;
   logic [15:0]           half_v;
   logic [31:0]           steer;

   // Request decode for the port IDLE would accept. Only the low OW bits of
   // the offset reach the RAM, which gives the wrap modulo the RAM size.
   // Bases are word aligned, so off[1:0] equals the address byte lane.
   always_comb begin
      req_size = bus.d_req ? bus.d_size : 2'b10;
      off      = bus.d_req ? (bus.d_addr[OW-1:0] - DBASE[OW-1:0])
                           : (bus.i_addr[OW-1:0] - IBASE[OW-1:0]);
      is_store = bus.d_req & bus.d_we;
      case (bus.d_size)
         2'b00: begin
            st_be    = 4'b0001 << off[1:0];
            st_wdata = {4{bus.d_wdata[7:0]}};
         end
         2'b01: begin
            st_be    = off[1] ? 4'b1100 : 4'b0011;
            st_wdata = {2{bus.d_wdata[15:0]}};
         end
         default: begin
            st_be    = 4'b1111;
            st_wdata = bus.d_wdata;
         end
      endcase
   end

`ifdef MEM_FAULT_EN
   logic [31:0] off_full;
   // Addresses below the base wrap to huge offsets and fail the range test.
   always_comb begin
      off_full  = bus.d_req ? (bus.d_addr - DBASE) : (bus.i_addr - IBASE);
      acc_fault = (off_full >= (32'd4 << DEPTH_LOG2))
                | ((req_size == 2'b01) & off[0])
                | (req_size[1] & (off[1:0] != 2'b00));
   end
`else
   assign acc_fault = 1'b0;
`endif

   // Load steering from the raw RAM word at the end of the window.
   always_comb begin
      byte_v = bus.m_rdata[{lane_q, 3'b000} +: 8];
      half_v = lane_q[1] ? bus.m_rdata[31:16] : bus.m_rdata[15:0];
      case (size_q)
         2'b00:   steer = {{24{sgn_q & byte_v[7]}}, byte_v};
         2'b01:   steer = {{16{sgn_q & half_v[15]}}, half_v};
         default: steer = bus.m_rdata;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      wait_d    = wait_q;
      is_d_d    = is_d_q;
      st_d      = st_q;
      size_d    = size_q;
      sgn_d     = sgn_q;
      lane_d    = lane_q;
      flt_d     = flt_q;
      rd_d      = rd_q;
      m_en_d    = 1'b0;
      m_we_d    = 1'b0;
      m_be_d    = m_be_q;
      m_addr_d  = m_addr_q;
      m_wdata_d = m_wdata_q;
      i_ack_d   = 1'b0;
      d_ack_d   = 1'b0;
      i_rdata_d = i_rdata_q;
      d_rdata_d = d_rdata_q;
      fault_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.d_req || bus.i_req) begin
               is_d_d    = bus.d_req;
               st_d      = is_store;
               size_d    = req_size;
               sgn_d     = bus.d_signed;
               lane_d    = off[1:0];
               flt_d     = acc_fault;
               rd_d      = 32'h0;
               wait_d    = 3'(WAIT_STATES);
               m_addr_d  = off[OW-1:2];
               m_be_d    = is_store ? st_be : 4'b1111;
               m_wdata_d = is_store ? st_wdata : 32'h0;
               m_en_d    = ~acc_fault;
               m_we_d    = ~acc_fault & is_store;
               state_d   = bus.d_req ? DACC : IACC;
            end
         end
         IACC, DACC: begin
            if (flt_q) begin
               state_d = ACK;
            end else if (wait_q == 3'd0) begin
               if (!st_q) rd_d = steer;
               state_d = ACK;
            end else begin
               wait_d = wait_q - 3'd1;
               m_en_d = 1'b1;
               m_we_d = m_we_q;
            end
         end
         ACK: begin
            state_d = IDLE;
            fault_d = flt_q;
            if (is_d_q) begin
               d_ack_d = 1'b1;
               // Stores leave d_rdata alone unless they fault.
               if (!st_q || flt_q) d_rdata_d = rd_q;
            end else begin
               i_ack_d   = 1'b1;
               i_rdata_d = rd_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         wait_q    <= 3'd0;
         is_d_q    <= 1'b0;
         st_q      <= 1'b0;
         size_q    <= 2'b00;
         sgn_q     <= 1'b0;
         lane_q    <= 2'b00;
         flt_q     <= 1'b0;
         rd_q      <= 32'h0;
         m_en_q    <= 1'b0;
         m_we_q    <= 1'b0;
         m_be_q    <= 4'h0;
         m_addr_q  <= '0;
         m_wdata_q <= 32'h0;
         i_ack_q   <= 1'b0;
         d_ack_q   <= 1'b0;
         i_rdata_q <= 32'h0;
         d_rdata_q <= 32'h0;
         fault_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         is_d_q    <= is_d_d;
         st_q      <= st_d;
         size_q    <= size_d;
         sgn_q     <= sgn_d;
         lane_q    <= lane_d;
         flt_q     <= flt_d;
         rd_q      <= rd_d;
         m_en_q    <= m_en_d;
         m_we_q    <= m_we_d;
         m_be_q    <= m_be_d;
         m_addr_q  <= m_addr_d;
         m_wdata_q <= m_wdata_d;
         i_ack_q   <= i_ack_d;
         d_ack_q   <= d_ack_d;
         i_rdata_q <= i_rdata_d;
         d_rdata_q <= d_rdata_d;
         fault_q   <= fault_d;
      end
   end

   assign bus.busy    = (state_q != IDLE);
   assign bus.fault   = fault_q;
   assign bus.i_ack   = i_ack_q;
   assign bus.d_ack   = d_ack_q;
   assign bus.i_rdata = i_rdata_q;
   assign bus.d_rdata = d_rdata_q;
   assign bus.m_en    = m_en_q;
   assign bus.m_we    = m_we_q;
   assign bus.m_be    = m_be_q;
   assign bus.m_addr  = m_addr_q;
   assign bus.m_wdata = m_wdata_q;
endmodule

// File: doc/mem_bridge.md
# mem_bridge

Parametrised memory bridge placed between the CPU core and a single-port synchronous word RAM. It serves instruction-fetch and data requests through one memory port, translates MARS-style addresses (text and data bases) into word indices, and performs byte and halfword lane steering with sign or zero extension for LB/LBU/LH/LHU/SB/SH. It is a multi-cycle successor to the fixed single-cycle IMEM/DMEM hookup at the top level, and adds request/acknowledge handshakes and configurable wait states.

## Interface
- DEPTH_LOG2, 11, word-address width of the RAM; capacity is 4<<DEPTH_LOG2 bytes per region
- WAIT_STATES, 1, extra RAM cycles per access; 0 to 7
- IBASE, 32'h00400000, instruction region base address
- DBASE, 32'h10010000, data region base address
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- i_req  in  1  fetch request; held with i_addr until i_ack
- i_addr  in  32  fetch byte address
- i_rdata  out  32  fetched word; valid with i_ack and held until the next i_ack
- i_ack  out  1  one-cycle completion pulse
- d_req  in  1  data request; held with the d_* inputs until d_ack
- d_we  in  1  1 = store
- d_size  in  2  00 byte, 01 half, 10 word; 11 is treated as word
- d_signed  in  1  sign-extend loads when 1
- d_addr  in  32  data byte address
- d_wdata  in  32  store data, right-aligned
- d_rdata  out  32  extended load data; valid with d_ack and held until the next d_ack
- d_ack  out  1  one-cycle completion pulse
- busy  out  1  high whenever state is not IDLE
- fault  out  1  access-fault pulse coincident with an ack
- m_en  out  1  RAM access strobe
- m_we  out  1  RAM write
- m_be  out  4  byte enables; bit n = byte lane n, little-endian
- m_addr  out  DEPTH_LOG2  word index
- m_wdata  out  32  lane-replicated write data
- m_rdata  in  32  RAM read word, valid WAIT_STATES+1 cycles after m_en rises

## Operation
- The FSM has four states: IDLE, IACC, DACC, and ACK.
- In IDLE, a pending d_req is served before a pending i_req; if both are high, the bridge goes to DACC.
- Offset is addr − base, computed modulo 2^32. m_addr is offset[DEPTH_LOG2+1:2].
- Byte store: m_be = 1<<addr[1:0]; m_wdata = {4{d_wdata[7:0]}}.
- Half store: m_be = addr[1] ? 1100 : 0011; m_wdata = {2{d_wdata[15:0]}}.
- Word store: m_be = 1111.
- Loads and fetches drive m_be = 1111 and m_we = 0.
- Load byte: extract lane addr[1:0]. Load half: extract lane addr[1]. The result is zero- or sign-extended according to d_signed.
- In IACC and DACC, m_en and m_addr/m_be/m_wdata stay stable for WAIT_STATES+1 cycles. m_we stays high for the whole window of a store; repeating the write is idempotent.
- On the final edge of the window, m_rdata is captured and steered. The FSM then goes to ACK, which pulses the matching ack for one cycle, and returns to IDLE.
- A request still high in the cycle after its ack is a new transaction.
- A store returns d_ack with d_rdata unchanged.

## Timing
- Reset values: state IDLE, i_ack/d_ack 0, i_rdata/d_rdata 0, m_en/m_we 0, m_be 0, m_addr 0, m_wdata 0, fault 0, busy 0.
- Request-to-ack latency: req sampled at edge k, ack high for the cycle after edge k+WAIT_STATES+2. With WAIT_STATES=1, ack arrives 3 cycles after req.
- Back-to-back throughput is one access per WAIT_STATES+3 cycles.
- Two requests arriving simultaneously cost two full access windows: data first, then fetch.
- Reset asserted mid-access aborts immediately and no ack is issued. A RAM write already strobed is not rolled back.
- A request deasserted before its ack is a protocol violation; behaviour is undefined.

## Configuration
- MEM_FAULT_EN defined:
  - A fault is an access that is misaligned (half with addr[0]=1, word with addr[1:0]≠0) or whose offset is ≥ 4<<DEPTH_LOG2; an address below its base wraps to a large offset and therefore faults.
  - A faulting access skips the RAM window entirely (no m_en, no write).
  - It goes straight to ACK one cycle after acceptance, returns rdata 0, and raises fault together with the ack.
- MEM_FAULT_EN undefined:
  - fault is tied to 0.
  - Misaligned low bits are ignored (access is aligned down).
  - The offset wraps modulo the RAM size.

## Test plan
- Reset, then i_req at i_addr 0x00400008 with m_rdata 0x2402000A → m_addr 2; i_ack after 3 cycles; i_rdata 0x2402000A.
- Store byte 0x1234_56AB at d_addr 0x10010005 → m_addr 1, m_be 0010, m_wdata 0xABABABAB. Then load byte with d_signed=1 from RAM word 0x0000AB00 → d_rdata 0xFFFFFFAB; with d_signed=0 → 0x000000AB.
- i_req and d_req raised in the same cycle → d_ack first, i_ack WAIT_STATES+3 cycles later; busy stays high across both.
- WAIT_STATES=3: m_en held for 4 cycles; ack 5 cycles after req.
- MEM_FAULT_EN defined: half load at 0x10010003 → no m_en, d_ack and fault high 2 cycles after req, d_rdata 0. Undefined: the same access reads lane 1 of word 0 and fault stays 0.
- rst pulsed during DACC → all outputs return to reset values asynchronously and no d_ack appears; a re-issued request completes normally.
